// File: rtl/bios_loader_pkg.sv
// Board configuration shared by the boot-time loaders.
// Flash/RAM map of the BIOS and megarom images plus loader types.
package CONFIG;

  localparam int ENABLE_NEXTOR  = 1;
  localparam int ENABLE_FM      = 0;
  localparam int ENABLE_MEGAROM = 1;

  localparam logic [23:0] FLASH_SIZE_BIOS    = 24'h00C000;
  localparam logic [23:0] FLASH_SIZE_MEGAROM = 24'h040000;

  localparam logic [23:0] FLASH_ADDR_BIOS    = 24'h100000;
  localparam logic [23:0] RAM_ADDR_BIOS      = 24'h700000;
  localparam logic [23:0] FLASH_ADDR_MEGAROM = 24'h200000;
  localparam logic [23:0] RAM_ADDR_MEGAROM   = 24'h400000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_SEL  = 2'd1,
    LD_COPY = 2'd2,
    LD_DONE = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic [23:0] src;
    logic [23:0] dst;
    logic [23:0] size;
  } region_t;

endpackage

// File: rtl/bios_loader.sv
// Boot-time copier: streams the BIOS and megarom images from flash
// into RAM through a one-byte buffer, then raises a sticky done.
module bios_loader
  import CONFIG::*;
#(
  parameter int          ENABLE_BIOS_COPY    =
    CONFIG::ENABLE_NEXTOR | CONFIG::ENABLE_FM,
  parameter int          ENABLE_MEGAROM_COPY = CONFIG::ENABLE_MEGAROM,
  parameter logic [23:0] BIOS_SIZE           = CONFIG::FLASH_SIZE_BIOS,
  parameter logic [23:0] MEGAROM_SIZE        = CONFIG::FLASH_SIZE_MEGAROM
) (
  input  logic        clk,
  input  logic        reset,
  output logic        flash_req,
  output logic [23:0] flash_addr,
  input  logic        flash_ack,
  input  logic [7:0]  flash_rdata,
  output logic        ram_req,
  output logic [23:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done
);

  localparam region_t REG0 = '{
    src:  FLASH_ADDR_BIOS,
    dst:  RAM_ADDR_BIOS,
    size: BIOS_SIZE
  };
  localparam region_t REG1 = '{
    src:  FLASH_ADDR_MEGAROM,
    dst:  RAM_ADDR_MEGAROM,
    size: MEGAROM_SIZE
  };

  localparam bit USE0 =
    (ENABLE_BIOS_COPY != 0) && (BIOS_SIZE != 24'd0);
  localparam bit USE1 =
    (ENABLE_MEGAROM_COPY != 0) && (MEGAROM_SIZE != 24'd0);

  loader_state_t state;
  logic [1:0]    idx;
  logic [23:0]   src_addr;
  logic [23:0]   dst_addr;
  logic [23:0]   rd_cnt;
  logic [23:0]   wr_cnt;
  logic [7:0]    buf_data;
  logic          buf_full;

  logic          in_copy;
  logic          rd_fire;
  logic          wr_fire;
  logic          last_wr;

  logic          sel_go;
  logic [1:0]    sel_idx;
  region_t       sel_reg;

  assign in_copy = (state == LD_COPY);

  // A read may issue into a buffer that is emptying this same cycle.
  assign flash_req = in_copy && (rd_cnt != 24'd0)
                     && (!buf_full || ram_ack);
  assign ram_req   = in_copy && buf_full;

  assign rd_fire = flash_req && flash_ack;
  assign wr_fire = ram_req && ram_ack;
  assign last_wr = wr_fire && (wr_cnt == 24'd1);

  assign flash_addr = src_addr;
  assign ram_addr   = dst_addr;
  assign ram_wdata  = buf_data;

  assign busy = (state == LD_SEL) || (state == LD_COPY);
  assign done = (state == LD_DONE);

  // Pick the next region at or after idx that has bytes to copy.
  always_comb begin
    sel_go  = 1'b0;
    sel_idx = idx;
    sel_reg = REG0;
    unique case (1'b1)
      (idx == 2'd0) && USE0: begin
        sel_go  = 1'b1;
        sel_idx = 2'd0;
        sel_reg = REG0;
      end
      ((idx == 2'd1) || ((idx == 2'd0) && !USE0)) && USE1: begin
        sel_go  = 1'b1;
        sel_idx = 2'd1;
        sel_reg = REG1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LD_IDLE;
      idx      <= 2'd0;
      src_addr <= 24'd0;
      dst_addr <= 24'd0;
      rd_cnt   <= 24'd0;
      wr_cnt   <= 24'd0;
      buf_data <= 8'd0;
      buf_full <= 1'b0;
    end else begin
      unique case (state)
        LD_IDLE: begin
          state <= LD_SEL;
          idx   <= 2'd0;
        end
        LD_SEL: begin
          if (sel_go) begin
            state    <= LD_COPY;
            idx      <= sel_idx;
            src_addr <= sel_reg.src;
            dst_addr <= sel_reg.dst;
            rd_cnt   <= sel_reg.size;
            wr_cnt   <= sel_reg.size;
          end else begin
            state <= LD_DONE;
          end
        end
        LD_COPY: begin
          if (rd_fire) begin
            buf_data <= flash_rdata;
            buf_full <= 1'b1;
            src_addr <= src_addr + 24'd1;
            rd_cnt   <= rd_cnt - 24'd1;
          end else if (wr_fire) begin
            buf_full <= 1'b0;
          end
          if (wr_fire) begin
            dst_addr <= dst_addr + 24'd1;
            wr_cnt   <= wr_cnt - 24'd1;
          end
          if (last_wr) begin
            state <= LD_SEL;
            idx   <= idx + 2'd1;
          end
        end
        LD_DONE: ;
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: three configurations run side by side,
// writes checked against a flash-to-RAM image model.
module tb_bios_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        freq  [3];
  logic        fack  [3];
  logic [7:0]  frd   [3];
  logic [23:0] faddr [3];
  logic        rreq  [3];
  logic        rack  [3];
  logic [23:0] raddr [3];
  logic [7:0]  wd    [3];
  logic        busy  [3];
  logic        done  [3];

  bios_loader #(
    .ENABLE_BIOS_COPY(1), .ENABLE_MEGAROM_COPY(1),
    .BIOS_SIZE(24'd4), .MEGAROM_SIZE(24'd3)
  ) u0 (
    .clk(clk), .reset(rst[0]),
    .flash_req(freq[0]), .flash_addr(faddr[0]),
    .flash_ack(fack[0]), .flash_rdata(frd[0]),
    .ram_req(rreq[0]), .ram_addr(raddr[0]),
    .ram_wdata(wd[0]), .ram_ack(rack[0]),
    .busy(busy[0]), .done(done[0])
  );

  bios_loader #(
    .ENABLE_BIOS_COPY(1), .ENABLE_MEGAROM_COPY(1),
    .BIOS_SIZE(24'd8), .MEGAROM_SIZE(24'd0)
  ) u1 (
    .clk(clk), .reset(rst[1]),
    .flash_req(freq[1]), .flash_addr(faddr[1]),
    .flash_ack(fack[1]), .flash_rdata(frd[1]),
    .ram_req(rreq[1]), .ram_addr(raddr[1]),
    .ram_wdata(wd[1]), .ram_ack(rack[1]),
    .busy(busy[1]), .done(done[1])
  );

  bios_loader #(
    .ENABLE_BIOS_COPY(0), .ENABLE_MEGAROM_COPY(0),
    .BIOS_SIZE(24'd4), .MEGAROM_SIZE(24'd3)
  ) u2 (
    .clk(clk), .reset(rst[2]),
    .flash_req(freq[2]), .flash_addr(faddr[2]),
    .flash_ack(fack[2]), .flash_rdata(frd[2]),
    .ram_req(rreq[2]), .ram_addr(raddr[2]),
    .ram_wdata(wd[2]), .ram_ack(rack[2]),
    .busy(busy[2]), .done(done[2])
  );

  int en0 [3] = '{1, 1, 0};
  int sz0 [3] = '{4, 8, 4};
  int en1 [3] = '{1, 1, 0};
  int sz1 [3] = '{3, 0, 3};

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int rel;
  int fpct [3];
  int rpct [3];
  int wi [3];
  int rd [3];
  int first_wr [3];
  int last_wr [3];
  bit hold_r [3];
  bit hold_f [3];
  bit chk_first [3];
  bit any_req [3];
  logic [23:0] pra [3];
  logic [23:0] pfa [3];
  logic [7:0]  pwd [3];
  int fp_tab [3] = '{100, 30, 90};
  int rp_tab [3] = '{100, 85, 25};

  function automatic logic [7:0] fmem(logic [23:0] a);
    return (a[7:0] ^ a[23:16]) + 8'h3C;
  endfunction

  function automatic int total(int i);
    return (en0[i] != 0 ? sz0[i] : 0) + (en1[i] != 0 ? sz1[i] : 0);
  endfunction

  // k-th RAM write expected from instance i: region 0 bytes, then region 1.
  function automatic logic [31:0] exp_wr(int i, int k);
    int n0;
    logic [23:0] a;
    logic [23:0] f;
    n0 = (en0[i] != 0) ? sz0[i] : 0;
    if (k < n0) begin
      a = 24'h700000 + 24'(k);
      f = 24'h100000 + 24'(k);
    end else begin
      a = 24'h400000 + 24'(k - n0);
      f = 24'h200000 + 24'(k - n0);
    end
    return {a, fmem(f)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++)
      rack[i] = rreq[i] && (int'($urandom_range(0, 99)) < rpct[i]);
    #1;
    for (int i = 0; i < 3; i++) begin
      fack[i] = freq[i] && (int'($urandom_range(0, 99)) < fpct[i]);
      frd[i]  = fack[i] ? fmem(faddr[i]) : 8'($urandom);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        hold_r[i] = 1'b0;
        hold_f[i] = 1'b0;
      end else begin
        if (hold_r[i])
          chk("ram_hold", {raddr[i], wd[i]}, {pra[i], pwd[i]});
        if (hold_f[i])
          chk("flash_hold", faddr[i], pfa[i]);
        hold_r[i] = rreq[i] && !rack[i];
        hold_f[i] = freq[i] && !fack[i];
        pra[i] = raddr[i];
        pwd[i] = wd[i];
        pfa[i] = faddr[i];
        if (freq[i] || rreq[i]) any_req[i] = 1'b1;
        if (freq[i] && chk_first[i]) begin
          chk("first_faddr", faddr[i], 24'h100000);
          chk_first[i] = 1'b0;
        end
        if (freq[i] && fack[i]) rd[i]++;
        if (rreq[i] && rack[i]) begin
          chk("write_in_range", wi[i] < total(i), 1);
          chk($sformatf("write%0d_%0d", i, wi[i]),
              {raddr[i], wd[i]}, exp_wr(i, wi[i]));
          if (wi[i] == 0) first_wr[i] = cyc + 1;
          last_wr[i] = cyc + 1;
          wi[i]++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear0();
    wi[0] = 0;
    rd[0] = 0;
    chk_first[0] = 1'b1;
  endtask

  task automatic run0();
    for (int t = 0; t < 500 && !done[0]; t++) tick();
    chk("done_timeout", done[0], 1);
    chk("writes7", wi[0], 7);
    chk("done_lag", cyc - last_wr[0], 1);
    chk("first_seen", chk_first[0], 0);
    repeat (3) tick();
    chk("done_sticky", {done[0], busy[0], freq[0], rreq[0]}, 4'b1000);
    chk("no_extra", wi[0], 7);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      fack[i] = 1'b0;
      rack[i] = 1'b0;
      frd[i] = 8'd0;
      wi[i] = 0;
      rd[i] = 0;
      first_wr[i] = 0;
      last_wr[i] = 0;
      hold_r[i] = 1'b0;
      hold_f[i] = 1'b0;
      any_req[i] = 1'b0;
      chk_first[i] = 1'b0;
    end
    fpct = '{100, 100, 100};
    rpct = '{0, 100, 100};
    @(negedge clk);
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outs%0d", i),
          {freq[i], rreq[i], busy[i], done[i],
           faddr[i], raddr[i], wd[i]}, 0);

    rst = '{0, 0, 0};
    chk_first[0] = 1'b1;
    chk_first[1] = 1'b1;
    rel = cyc;
    tick();
    chk("skip_busy_e1", busy[2], 1);
    chk("skip_done_e1", done[2], 0);
    tick();
    chk("skip_done_e2", done[2], 1);
    chk("skip_busy_e2", busy[2], 0);
    repeat (10) tick();

    chk("bp_freq", freq[0], 0);
    chk("bp_rreq", rreq[0], 1);
    chk("bp_outstanding", rd[0] - wi[0], 1);
    chk("bp_no_write", wi[0], 0);

    chk("tp_writes", wi[1], 8);
    chk("tp_fill", first_wr[1] - rel, 4);
    chk("tp_span", last_wr[1] - first_wr[1], 7);
    chk("tp_done", done[1], 1);

    fpct[0] = 60;
    rpct[0] = 60;
    for (int t = 0; t < 300 && wi[0] < 2; t++) tick();
    chk("pre_abort_writes", wi[0], 2);
    rst[0] = 1'b1;
    tick();
    chk("abort_reqs", {freq[0], rreq[0], busy[0]}, 3'b000);
    tick();
    rst[0] = 1'b0;
    clear0();
    run0();

    for (int r = 0; r < 3; r++) begin
      rst[0] = 1'b1;
      tick();
      chk("rerun_reset",
          {freq[0], rreq[0], busy[0], done[0],
           faddr[0], raddr[0], wd[0]}, 0);
      rst[0] = 1'b0;
      fpct[0] = fp_tab[r];
      rpct[0] = rp_tab[r];
      clear0();
      run0();
    end

    chk("skip_never_req", any_req[2], 0);
    chk("skip_done_final", done[2], 1);
    chk("tp_final_writes", wi[1], 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
